// File: rtl/inst_fetch.sv
// Instruction fetch stage: writable program store, PC and a one-entry valid/ready output slot.
// Optional HALT_DETECT_EN: an all-ones word ends the program early instead of being issued.
module inst_fetch #(
  parameter int unsigned INST_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PC_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_prog_we,
  input  logic [PC_W-1:0]   i_prog_addr,
  input  logic [INST_W-1:0] i_prog_data,
  input  logic [PC_W:0]     i_prog_len,
  input  logic              i_start,
  input  logic              i_redirect,
  input  logic [PC_W-1:0]   i_redirect_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic [INST_W-1:0] o_inst_out,
  output logic [PC_W-1:0]   o_pc_out,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [PC_W:0] LenMax = (PC_W+1)'(DEPTH);

  state_e              r_state, w_state_next;
  logic [INST_W-1:0]   r_mem [DEPTH];
  logic [PC_W:0]       r_pc, w_pc_next;
  logic [PC_W:0]       r_len, w_len_next;
  logic [INST_W-1:0]   r_inst, w_inst_next;
  logic [PC_W-1:0]     r_pc_out, w_pc_out_next;
  logic                r_valid, w_valid_next;
  logic                w_slot_free;
  logic                w_halt;
  logic [INST_W-1:0]   w_fetch_word;

  assign w_slot_free  = !r_valid || i_inst_ready;
  // pc < len <= DEPTH whenever the word is used, so the low bits always index in range
  assign w_fetch_word = r_mem[r_pc[PC_W-1:0]];

`ifdef HALT_DETECT_EN
  assign w_halt = (w_fetch_word == {INST_W{1'b1}});
`else
  assign w_halt = 1'b0;
`endif

  // Store is deliberately left out of reset; reset still blocks writes.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_prog_we && (r_state == StIdle)) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_pc     <= '0;
      r_len    <= '0;
      r_inst   <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_len    <= w_len_next;
      r_inst   <= w_inst_next;
      r_pc_out <= w_pc_out_next;
      r_valid  <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_len_next    = r_len;
    w_inst_next   = r_inst;
    w_pc_out_next = r_pc_out;
    w_valid_next  = r_valid;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_pc_next    = '0;
          w_len_next   = (i_prog_len > LenMax) ? LenMax : i_prog_len;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (i_redirect) begin
          // An accepted word is already gone; an unaccepted one is flushed here.
          w_pc_next    = {1'b0, i_redirect_pc};
          w_valid_next = 1'b0;
        end else if (r_pc >= r_len) begin
          w_state_next = StDrain;
          if (w_slot_free) begin
            w_valid_next = 1'b0;
          end
        end else if (w_slot_free) begin
          if (w_halt) begin
            w_valid_next = 1'b0;
            w_state_next = StDrain;
          end else begin
            w_inst_next   = w_fetch_word;
            w_pc_out_next = r_pc[PC_W-1:0];
            w_valid_next  = 1'b1;
            w_pc_next     = r_pc + (PC_W+1)'(1);
          end
        end
      end
      StDrain: begin
        if (i_redirect) begin
          w_pc_next    = {1'b0, i_redirect_pc};
          w_valid_next = 1'b0;
          w_state_next = StRun;
        end else if (w_slot_free) begin
          w_valid_next = 1'b0;
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  assign o_inst_valid = r_valid;
  assign o_inst_out   = r_inst;
  assign o_pc_out     = r_pc_out;
  assign o_busy       = (r_state == StRun) || (r_state == StDrain);
  assign o_done       = (r_state == StDone);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a negedge monitor pops the expected-word scoreboard on each
// accepted word; cycle-exact checks cover latency, stalls, redirects, reset and empty programs.
module tb_inst_fetch;

  logic       clk;
  logic       reset;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] prog_len;
  logic       start;
  logic       redirect;
  logic [3:0] redirect_pc;
  logic       inst_valid;
  logic       inst_ready;
  logic [7:0] inst_out;
  logic [3:0] pc_out;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [11:0] sb[$];
  logic [11:0] mon_exp;
  logic [7:0]  prog [4] = '{8'h1B, 8'h46, 8'h9C, 8'hE1};

  inst_fetch #(.INST_W(8), .DEPTH(16), .PC_W(4)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_prog_we    (prog_we),
    .i_prog_addr  (prog_addr),
    .i_prog_data  (prog_data),
    .i_prog_len   (prog_len),
    .i_start      (start),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_inst_valid (inst_valid),
    .i_inst_ready (inst_ready),
    .o_inst_out   (inst_out),
    .o_pc_out     (pc_out),
    .o_busy       (busy),
    .o_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sb.push_back({i[3:0], prog[i]});
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  // Each word accepted at the coming edge must be the next expected one.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      n_vec++;
      assert (sb.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_word: observed pc %0h inst %0h expected none", pc_out, inst_out);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("accepted_word", {20'd0, pc_out, inst_out}, {20'd0, mon_exp});
      end
    end
  end

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'd0, inst_valid}, 0);
    chk("rst_inst", {24'd0, inst_out}, 0);
    chk("rst_pc_out", {28'd0, pc_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prog_we = 1'b1; prog_addr = i[3:0]; prog_data = prog[i];
      tick();
    end
    prog_we = 1'b0;

    // 1: full-rate stream, latency and end-of-program
    done_cnt = 0; push_range(0, 3); inst_ready = 1'b1; prog_len = 5'd4; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_c1_valid", {31'd0, inst_valid}, 0);
    chk("t1_c1_busy", {31'd0, busy}, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t1_valid", {31'd0, inst_valid}, 1);
      chk("t1_pc_out", {28'd0, pc_out}, c);
    end
    tick();
    chk("t1_c6_valid", {31'd0, inst_valid}, 0);
    chk("t1_c6_busy", {31'd0, busy}, 1);
    chk("t1_c6_done", {31'd0, done}, 0);
    tick();
    chk("t1_c7_done", {31'd0, done}, 1);
    chk("t1_c7_busy", {31'd0, busy}, 0);
    tick();
    chk("t1_c8_done", {31'd0, done}, 0);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_done_cnt", done_cnt, 1);

    // 2: three-cycle stall on the first word
    done_cnt = 0; push_range(0, 3); inst_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t2_c2_valid", {31'd0, inst_valid}, 1);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      chk("t2_hold_inst", {24'd0, inst_out}, 32'h1B);
      chk("t2_hold_pc", {28'd0, pc_out}, 0);
    end
    inst_ready = 1'b1;
    tick();
    chk("t2_next_inst", {24'd0, inst_out}, 32'h46);
    chk("t2_next_pc", {28'd0, pc_out}, 1);
    wait_done("t2_done");
    tick(); tick();
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: redirect flushes a stalled word
    done_cnt = 0; push_range(0, 1); inst_ready = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t3_pending_pc", {28'd0, pc_out}, 2);
    chk("t3_pending_inst", {24'd0, inst_out}, 32'h9C);
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 4'd0; push_range(0, 3);
    tick(); redirect = 1'b0; inst_ready = 1'b1;
    chk("t3_flush_valid", {31'd0, inst_valid}, 0);
    tick();
    chk("t3_after_inst", {24'd0, inst_out}, 32'h1B);
    chk("t3_after_pc", {28'd0, pc_out}, 0);
    wait_done("t3_done");
    tick(); tick();
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: redirect in the same cycle the last word is accepted
    done_cnt = 0; push_range(0, 3); start = 1'b1;
    tick(); start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("t4_last_pc", {28'd0, pc_out}, 3);
    redirect = 1'b1; redirect_pc = 4'd1; push_range(1, 3);
    tick(); redirect = 1'b0;
    chk("t4_gap_valid", {31'd0, inst_valid}, 0);
    tick();
    chk("t4_after_inst", {24'd0, inst_out}, 32'h46);
    chk("t4_after_pc", {28'd0, pc_out}, 1);
    wait_done("t4_done");
    tick(); tick();
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_done_cnt", done_cnt, 1);

    // 5: empty program
    done_cnt = 0; prog_len = 5'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_c1_valid", {31'd0, inst_valid}, 0);
    tick();
    chk("t5_c2_done", {31'd0, done}, 0);
    tick();
    chk("t5_c3_done", {31'd0, done}, 1);
    chk("t5_c3_valid", {31'd0, inst_valid}, 0);
    tick();
    chk("t5_c4_done", {31'd0, done}, 0);
    chk("t5_done_cnt", done_cnt, 1);

    // 6: store write while running is ignored; reset mid-run; restart
    prog_len = 5'd4; push_range(0, 0); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t6_pc0", {28'd0, pc_out}, 0);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h77;
    tick(); prog_we = 1'b0; reset = 1'b1; inst_ready = 1'b0;
    tick(); reset = 1'b0;
    chk("t6_rst_valid", {31'd0, inst_valid}, 0);
    chk("t6_rst_inst", {24'd0, inst_out}, 0);
    chk("t6_rst_pc_out", {28'd0, pc_out}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_done", {31'd0, done}, 0);
    chk("t6_sb_empty_rst", sb.size(), 0);
    done_cnt = 0; inst_ready = 1'b1; push_range(0, 3); start = 1'b1;
    tick(); start = 1'b0;
    tick();
    chk("t6_restart_inst", {24'd0, inst_out}, 32'h1B);
    wait_done("t6_done");
    tick(); tick();
    chk("t6_sb_empty", sb.size(), 0);
    chk("t6_done_cnt", done_cnt, 1);

`ifdef HALT_DETECT_EN
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'hFF;
    tick(); prog_we = 1'b0;
    done_cnt = 0; push_range(0, 1); start = 1'b1;
    tick(); start = 1'b0;
    wait_done("halt_done");
    tick(); tick();
    chk("halt_sb_empty", sb.size(), 0);
    chk("halt_done_cnt", done_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
